pc_fetch_sequencer: RTL

Program-counter and fetch sequencer sitting directly upstream of the five-stage pipelined CPU core. It owns the architectural PC register, drives the core's instruction address input, and advances it to the core's PC+4 output only when the core's hazard unit asserts `PCWrite`. It also sequences program start, end-of-program drain and halt, traps misaligned fetch addresses, and optionally keeps fetch performance counters.

---
 rtl/pc_fetch_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and fetch sequencer for the five-stage core: start, sequential fetch, drain, halt and trap.
// Optional fetch performance counters are built only when PERF_CNT_EN is defined.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] END_ADDR     = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        PCWrite,
    input  logic [31:0] NextAddr,
    output logic [31:0] PCAddr,
    output logic        Running,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] CycleCount,
    output logic [31:0] StallCount,
    output logic [31:0] FetchCount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        HALT  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Drain counter is loaded with one less than the number of DRAIN cycles; HALT follows the cycle it reads 0.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [3:0]  drain_reg, drain_next;
    logic        running_reg, halted_reg, fault_reg;
    logic        clear_cnt, cycle_inc, stall_inc, fetch_inc;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drain_next = drain_reg;
        clear_cnt  = 1'b0;
        cycle_inc  = 1'b0;
        stall_inc  = 1'b0;
        fetch_inc  = 1'b0;
        case (state_reg)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = RESET_VECTOR;
                    clear_cnt  = 1'b1;
                end
            end
            RUN: begin
                cycle_inc = 1'b1;
                if (!PCWrite) begin
                    stall_inc = 1'b1;
                end else if (NextAddr[1:0] != 2'b00) begin
                    state_next = ERROR;
                    pc_next    = END_ADDR;
                end else if (NextAddr >= END_ADDR) begin
                    state_next = DRAIN;
                    pc_next    = END_ADDR;
                    drain_next = DRAIN_LOAD;
                end else begin
                    pc_next   = NextAddr;
                    fetch_inc = 1'b1;
                end
            end
            DRAIN: begin
                cycle_inc = 1'b1;
                pc_next   = END_ADDR;
                if (drain_reg == 4'd0) begin
                    state_next = HALT;
                end else begin
                    drain_next = drain_reg - 4'd1;
                end
            end
            ERROR: begin
                pc_next = END_ADDR;
            end
            default: begin
                state_next = IDLE;
                pc_next    = END_ADDR;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= END_ADDR;
            drain_reg   <= 4'd0;
            running_reg <= 1'b0;
            halted_reg  <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            drain_reg   <= drain_next;
            running_reg <= (state_next == RUN);
            halted_reg  <= (state_next == HALT);
            fault_reg   <= (state_next == ERROR);
        end
    end

    assign PCAddr  = pc_reg;
    assign Running = running_reg;
    assign Halted  = halted_reg;
    assign Fault   = fault_reg;

`ifdef PERF_CNT_EN
    logic [31:0] cnt_reg [3];
    logic [2:0]  cnt_inc;

    assign cnt_inc = {fetch_inc, stall_inc, cycle_inc};

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) cnt_reg[i] <= 32'h0;
        end else if (clear_cnt) begin
            for (int i = 0; i < 3; i++) cnt_reg[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_inc[i] && (cnt_reg[i] != 32'hFFFF_FFFF)) begin
                    cnt_reg[i] <= cnt_reg[i] + 32'd1;
                end
            end
        end
    end

    assign CycleCount = cnt_reg[0];
    assign StallCount = cnt_reg[1];
    assign FetchCount = cnt_reg[2];
`else
    logic unused_cnt;
    assign unused_cnt = ^{clear_cnt, cycle_inc, stall_inc, fetch_inc};
    assign CycleCount = 32'h0;
    assign StallCount = 32'h0;
    assign FetchCount = 32'h0;
`endif

endmodule
